// File: rtl/uart_pkg.sv
// Shared UART package.
//   Holds the data width, the default receive FIFO depth, the baud select
//   codes and the receiver state encodings, so that the RX, TX and register
//   blocks all use the same values.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int FIFO_ADDR_W_DEF = 4;

  // Baud select codes written by the register block.
  typedef enum logic [2:0] {
    BAUD_1200   = 3'b000,
    BAUD_2400   = 3'b001,
    BAUD_4800   = 3'b010,
    BAUD_9600   = 3'b011,
    BAUD_19200  = 3'b100,
    BAUD_38400  = 3'b101,
    BAUD_57600  = 3'b110,
    BAUD_115200 = 3'b111
  } baud_sel_e;

  // Receiver state encodings. The receiver exposes its state on a debug port
  // using this type.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_ERROR = 3'd4
  } rx_state_e;

  // Next pointer value for a power-of-two ring; wraps naturally.
  function automatic logic [FIFO_ADDR_W_DEF-1:0] ptr_inc(input logic [FIFO_ADDR_W_DEF-1:0] p);
    return p + FIFO_ADDR_W_DEF'(1);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO.
//   One synchronous write port and one asynchronous read port. The array is
//   not reset; occupancy tracking lives in the parent.
// Ports:
//   clock      - system clock
//   wr_en_i    - write mem[wr_addr_i] with wr_data_i on this edge
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address
//   rd_data_o  - mem[rd_addr_i], combinational
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic                   clock,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [UART_DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]      rd_addr_i,
  output logic [UART_DATA_W-1:0] rd_data_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer downstream of the UART receiver.
//   Captures each byte delivered by a one-cycle rec_valid pulse and presents
//   the oldest byte in first-word-fall-through order to the register block.
//   Reports fill level, empty/full, a sticky overrun flag and a registered
//   threshold interrupt.
// Handshake: the write side has no backpressure -- rec_valid is a one-cycle
//   strobe; a byte is taken when the FIFO has room (or a pop frees room in the
//   same cycle), otherwise it is dropped and overrun is set. The read side is a
//   strobe too: rd_en pops the head when !empty and is ignored when empty.
// Ports:
//   clock, resetn      - clock, synchronous active-low reset
//   uart_en            - low: incoming bytes ignored (no write, no overrun)
//   flush              - empty the FIFO; wins over push and pop
//   rec_valid, rec_dat - new byte strobe and data from the receiver
//   rd_en              - pop head entry
//   rd_data            - head entry, 8'h00 when empty
//   empty, full, level - occupancy status
//   thresh             - interrupt threshold, 0 disables
//   irq_thresh         - registered level >= thresh && thresh != 0
//   overrun, ovr_clr   - sticky dropped-byte flag and its clear strobe
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   uart_en,
  input  logic                   flush,
  input  logic                   rec_valid,
  input  logic [UART_DATA_W-1:0] rec_dat,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        level,
  input  logic [ADDR_W:0]        thresh,
  output logic                   irq_thresh,
  output logic                   overrun,
  input  logic                   ovr_clr
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        level_q, level_d;
  logic                   overrun_q, overrun_d;
  logic                   irq_q, irq_d;
  logic                   push, pop, ovr_evt;
  logic [UART_DATA_W-1:0] mem_rd;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign push    = rec_valid & uart_en & (~full | pop);
  assign ovr_evt = rec_valid & uart_en & full & ~pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push && !pop)      level_d = level_q + (ADDR_W + 1)'(1);
      else if (pop && !push) level_d = level_q - (ADDR_W + 1)'(1);
    end

    // Set beats clear; flush leaves the flag alone.
    if (ovr_evt)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;

    irq_d = (thresh != '0) && (level_d >= thresh);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (push & ~flush & resetn),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (rec_dat),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rd)
  );

  assign rd_data    = empty ? '0 : mem_rd;
  assign level      = level_q;
  assign overrun    = overrun_q;
  assign irq_thresh = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              resetn;
  logic              uart_en;
  logic              flush;
  logic              rec_valid;
  logic [7:0]        rec_dat;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   thresh;
  logic              irq_thresh;
  logic              overrun;
  logic              ovr_clr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .uart_en    (uart_en),
    .flush      (flush),
    .rec_valid  (rec_valid),
    .rec_dat    (rec_dat),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .thresh     (thresh),
    .irq_thresh (irq_thresh),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted read pops the scoreboard and compares the head.
  always @(negedge clock) begin
    if (resetn && rd_en && !empty) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rd_pop: got %0h, expected nothing (queue empty)", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          tests_failed++;
          $display("FAIL rd_data: got %0h, expected %0h", rd_data, e);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accepted);
    rec_valid = 1'b1;
    rec_dat   = d;
    if (accepted) exp_q.push_back(d);
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0; uart_en = 1'b1; flush = 1'b0; rec_valid = 1'b0;
    rec_dat = '0; rd_en = 1'b0; thresh = '0; ovr_clr = 1'b0;
    do_reset();

    // 1. reset state and basic FWFT
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_irq", irq_thresh, 0);
    check("rst_rd_data", rd_data, 0);
    push_byte(8'hA5, 1);
    check("t1_head_first", rd_data, 8'hA5);
    push_byte(8'h3C, 1);
    check("t1_level2", level, 2);
    pop_byte();
    check("t1_head_second", rd_data, 8'h3C);
    pop_byte();
    check("t1_empty", empty, 1);
    check("t1_rd_zero", rd_data, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;   // read while empty is ignored
    check("t1_rd_empty_level", level, 0);

    // 2. fill, overrun, drain
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    check("t2_full", full, 1);
    check("t2_level16", level, 16);
    check("t2_no_ovr_yet", overrun, 0);
    push_byte(8'h10, 0);
    check("t2_overrun", overrun, 1);
    check("t2_level_held", level, 16);
    for (int i = 0; i < 16; i++) pop_byte();
    check("t2_drained", empty, 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("t2_ovr_clr", overrun, 0);

    // 3. simultaneous push and pop at full
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1);
    rec_valid = 1'b1; rec_dat = 8'hEE; rd_en = 1'b1;
    exp_q.push_back(8'hEE);
    tick();
    rec_valid = 1'b0; rd_en = 1'b0;
    check("t3_level16", level, 16);
    check("t3_no_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) pop_byte();
    check("t3_drained", empty, 1);

    // 4. threshold interrupt
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i), 1);
    check("t4_irq_below", irq_thresh, 0);
    push_byte(8'h43, 1);
    check("t4_irq_at", irq_thresh, 1);
    pop_byte();
    check("t4_irq_after_pop", irq_thresh, 0);
    for (int i = 0; i < 3; i++) pop_byte();
    thresh = 5'd0;
    for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i), 1);
    check("t4_irq_disabled", irq_thresh, 0);
    for (int i = 0; i < 16; i++) pop_byte();

    // 5. flush priority, overrun interactions
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), 1);
    check("t5_level5", level, 5);
    flush = 1'b1; rec_valid = 1'b1; rec_dat = 8'h77;
    tick();
    flush = 1'b0; rec_valid = 1'b0;
    exp_q.delete();
    check("t5_flush_level", level, 0);
    check("t5_flush_empty", empty, 1);
    check("t5_flush_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 1);
    ovr_clr = 1'b1;
    push_byte(8'hFF, 0);
    ovr_clr = 1'b0;
    check("t5_set_wins", overrun, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    exp_q.delete();
    check("t5_flush_keeps_ovr", overrun, 1);
    check("t5_flush_level2", level, 0);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("t5_ovr_cleared", overrun, 0);

    // 6. uart_en low, then pointer wrap
    uart_en = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'h90 + 8'(i), 0);
    check("t6_disabled_level", level, 0);
    check("t6_disabled_ovr", overrun, 0);
    uart_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(i * 7 + 3), 1);
      pop_byte();
    end
    check("t6_wrap_empty", empty, 1);
    check("t6_queue_drained", exp_q.size(), 0);

    // reset mid-operation discards pending bytes
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 1);
    do_reset();
    check("rst_mid_level", level, 0);
    check("rst_mid_empty", empty, 1);
    push_byte(8'hD1, 1);
    pop_byte();
    check("rst_mid_final_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
